uart_tx_frame: RTL and testbench

// - Parametrised UART transmitter with a valid/ready input handshake.
// - Data width, bit order, stop-bit count and baud divisor are configurable; parity is optional.
// - Zero-gap back-to-back frames. Sits between a byte producer (FIFO or controller) and the pad.

---
 rtl/uart_tx_frame.sv | 118 +++++++++++
 tb/tb_uart_tx_frame.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with valid/ready input; optional parity bit enabled by UART_TX_PARITY_EN
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic                 serial_tx_o,
   output logic                 busy_o
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = 4;

   if (CLKS_PER_BIT < 2) begin : g_chk_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_chk_msb
      $error("uart_tx_frame: MSB_FIRST must be 0 or 1");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
      $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 serial_q, serial_d;
   logic                 rst_q;
   logic                 data_bit;
   logic                 tc, last_data, last_stop, accept;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign tc        = cnt_q == CW'(CLKS_PER_BIT - 1);
   assign last_data = bit_q == BW'(DATA_BITS - 1);
   assign last_stop = bit_q == BW'(STOP_BITS - 1);
   assign accept    = tx_valid_i && tx_ready_o;

   // State, counters and line register; rst_q keeps tx_ready low on the release cycle
   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   // Next state: advance on baud terminal count, re-enter START directly on a back-to-back accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   if (tc) state_d = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:    if (tc && last_data) state_d = PARITY;
         PARITY:  if (tc) state_d = STOP;
`else
         DATA:    if (tc && last_data) state_d = STOP;
`endif
         STOP:    if (tc && last_stop) state_d = accept ? START : IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d   = (state_q == IDLE || tc) ? '0 : cnt_q + CW'(1);
      bit_d   = !tc ? bit_q :
                ((state_q == DATA && !last_data) || (state_q == STOP && !last_stop)) ? bit_q + BW'(1) : '0;
      shift_d = accept ? tx_data_i :
                (state_q == DATA && tc) ? ((MSB_FIRST != 0) ? shift_q << 1 : shift_q >> 1) : shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = accept ? ((^tx_data_i) ^ (PARITY_ODD != 0)) : par_q;
`endif
   end

   // Outputs: next line level from next state so the start bit appears on the accept edge
   always_comb begin
      tx_ready_o = !rst && !rst_q && (state_q == IDLE || (state_q == STOP && tc && last_stop));
      busy_o     = state_q != IDLE;
      data_bit   = (MSB_FIRST != 0) ? shift_d[DATA_BITS-1] : shift_d[0];
`ifdef UART_TX_PARITY_EN
      serial_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? data_bit :
                   (state_d == PARITY) ? par_d : 1'b1;
`else
      serial_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? data_bit : 1'b1;
`endif
   end

   assign serial_tx_o = serial_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of uart_tx_frame line waveform, handshake, reset and back-to-back frames
module tb_uart_tx_frame;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] valid = '0;
   logic [3:0] ser, bsy, rdy;
   logic [7:0] data [4] = '{default: 8'h00};
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [127:0] line;
   int         nb, nl;

   always #5 clk = ~clk;

   uart_tx_frame #(.CLKS_PER_BIT(4)) u0 (
      .clk(clk), .rst(rst), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
      .tx_ready_o(rdy[0]), .serial_tx_o(ser[0]), .busy_o(bsy[0]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .MSB_FIRST(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
      .tx_ready_o(rdy[1]), .serial_tx_o(ser[1]), .busy_o(bsy[1]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(5)) u2 (
      .clk(clk), .rst(rst), .tx_data_i(data[2][4:0]), .tx_valid_i(valid[2]),
      .tx_ready_o(rdy[2]), .serial_tx_o(ser[2]), .busy_o(bsy[2]));
   uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u3 (
      .clk(clk), .rst(rst), .tx_data_i(data[3]), .tx_valid_i(valid[3]),
      .tx_ready_o(rdy[3]), .serial_tx_o(ser[3]), .busy_o(bsy[3]));

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // frame bits (bit 0 = first on the line) stretched to 4 clocks per bit
   function automatic logic [127:0] expand(logic [31:0] bits, int n);
      logic [127:0] r = '0;
      for (int i = 0; i < n * 4; i++) r[i] = bits[i / 4];
      return r;
   endfunction

   // insert the parity bit after the data bits when parity is built in
   function automatic logic [31:0] fr(logic [31:0] f, int nd, logic p);
      logic [31:0] lo = f & ((32'd1 << (1 + nd)) - 32'd1);
      return (P != 0) ? ((f >> (1 + nd)) << (2 + nd)) | (32'(p) << (1 + nd)) | lo : f;
   endfunction

   task automatic send(int d, logic [7:0] v);
      int w = 0;
      data[d] = v;
      valid[d] = 1'b1;
      while (!rdy[d] && w < 200) begin
         tick();
         w++;
      end
      check("ready_timeout", 128'(w < 200), 128'd1);
      tick();
   endtask

   task automatic run_frame(int d, output logic [127:0] l, output int nbusy, output int nlow);
      logic seen = 1'b0;
      l = '0;
      nbusy = 0;
      nlow = 0;
      valid[d] = 1'b0;
      for (int k = 0; k < 120 && bsy[d]; k++) begin
         l[k] = ser[d];
         nbusy++;
         if (!rdy[d] && !seen) nlow++;
         else seen = 1'b1;
         if (k == 2) data[d] = ~data[d];
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("rst_serial", ser, 4'hF);
      check("rst_busy", bsy, 4'h0);
      check("rst_ready", rdy, 4'h0);
      valid = 4'hF;
      rst = 1'b0;
      check("release_ready", rdy, 4'h0);
      valid = 4'h0;
      tick();
      check("idle_ready", rdy, 4'hF);
      check("idle_serial", ser, 4'hF);

      send(0, 8'hA5);
      run_frame(0, line, nb, nl);
      check("lsb_a5_line", line, expand(fr(32'h34A, 8, 1'b0), 10 + P));
      check("lsb_a5_busy", nb, 40 + 4 * P);
      check("lsb_a5_rdy_low", nl, 39 + 4 * P);

      send(1, 8'hA5);
      run_frame(1, line, nb, nl);
      check("msb_a5_line", line, expand(fr(32'h74A, 8, 1'b0), 11 + P));
      check("msb_a5_busy", nb, 44 + 4 * P);
      check("msb_a5_rdy_low", nl, 43 + 4 * P);
      send(1, 8'h01);
      run_frame(1, line, nb, nl);
      check("msb_01_line", line, expand(fr(32'h700, 8, 1'b1), 11 + P));

      send(2, 8'h1F);
      run_frame(2, line, nb, nl);
      check("db5_1f_line", line, expand(fr(32'h7E, 5, 1'b1), 7 + P));
      check("db5_1f_busy", nb, 28 + 4 * P);

`ifdef UART_TX_PARITY_EN
      send(3, 8'hA5);
      run_frame(3, line, nb, nl);
      check("odd_a5_line", line, expand(fr(32'h34A, 8, 1'b1), 11));
      check("odd_a5_busy", nb, 44);
`endif

      send(0, 8'h00);
      data[0] = 8'hFF;
      line = '0;
      nb = 0;
      for (int k = 0; k < 8 * (10 + P); k++) begin
         if (k == 4 * (10 + P)) valid[0] = 1'b0;
         line[k] = ser[0];
         if (bsy[0]) nb++;
         tick();
      end
      check("b2b_line", line,
            expand(fr(32'h200, 8, 1'b0) | (fr(32'h3FE, 8, 1'b0) << (10 + P)), 20 + 2 * P));
      check("b2b_busy", nb, 8 * (10 + P));
      check("b2b_end_busy", bsy[0], 1'b0);

      send(0, 8'hA5);
      valid[0] = 1'b0;
      repeat (15) tick();
      rst = 1'b1;
      tick();
      check("midrst_serial", ser[0], 1'b1);
      check("midrst_busy", bsy[0], 1'b0);
      check("midrst_ready", rdy[0], 1'b0);
      tick();
      rst = 1'b0;
      check("midrst_release_ready", rdy[0], 1'b0);
      send(0, 8'h3C);
      run_frame(0, line, nb, nl);
      check("post_rst_3c_line", line, expand(fr(32'h278, 8, 1'b0), 10 + P));
      check("post_rst_3c_busy", nb, 40 + 4 * P);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
